// File: rtl/alu_seq_exec.sv
// alu_seq_exec: multi-cycle execute unit. Single-cycle ALU ops finish at the
// acceptance edge; SLL/SRL/SRA walk one bit position per cycle so no barrel
// shifter is needed. Result and flags are registered and held until taken.
//
// Handshake: a request transfers on a rising edge where in_valid & in_ready;
// a result transfers on a rising edge where out_valid & out_ready. Once
// out_valid is high, result and flags hold until that transfer. in_ready
// depends combinationally only on out_ready (and reset), never on in_valid.
module alu_seq_exec #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             cf,
    output logic             vf,
    output logic             sf,
    output logic [1:0]       dbg_state
);

    // ALU_* operation encodings shared with the ALU control decode stage.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state;
    logic [SHW-1:0]   cnt;
    logic [3:0]       sel_q;

    logic             accept;
    logic             is_sub;
    logic             is_shift;
    logic [SHW-1:0]   shift_amt;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cf;
    logic             alu_vf;
    logic [WIDTH-1:0] sh_next;

    assign in_ready  = rst & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == ST_DONE);
    assign dbg_state = state;

    // Single-cycle ALU result and flags from the live request operands.
    always_comb begin
        is_sub    = (alu_sel == ALU_SUB);
        is_shift  = (alu_sel == ALU_SLL) | (alu_sel == ALU_SRL) | (alu_sel == ALU_SRA);
        shift_amt = op_b[SHW-1:0];
        // SUB is a + ~b + 1 so the carry-out means "no borrow".
        b_eff     = is_sub ? ~op_b : op_b;
        sum       = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        ovf       = (op_a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
        alu_res   = op_b;
        alu_cf    = 1'b0;
        alu_vf    = 1'b0;
        case (alu_sel)
            ALU_ADD, ALU_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_cf  = sum[WIDTH];
                alu_vf  = ovf;
            end
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            // A shift by zero completes immediately with the unshifted operand.
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
            ALU_PASS: alu_res = op_b;
            default:  alu_res = op_b;
        endcase
    end

    // One-bit shift step applied to the working value held in result.
    always_comb begin
        sh_next = result;
        case (sel_q)
            ALU_SLL: sh_next = {result[WIDTH-2:0], 1'b0};
            ALU_SRL: sh_next = {1'b0, result[WIDTH-1:1]};
            ALU_SRA: sh_next = {result[WIDTH-1], result[WIDTH-1:1]};
            default: sh_next = result;
        endcase
    end

    // Control FSM plus result/flag registers; result doubles as the shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            sel_q  <= '0;
            result <= '0;
            zf     <= 1'b0;
            cf     <= 1'b0;
            vf     <= 1'b0;
            sf     <= 1'b0;
        end else if (state == ST_SHIFT) begin
            result <= sh_next;
            cnt    <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
                state <= ST_DONE;
                zf    <= (sh_next == '0);
                cf    <= 1'b0;
                vf    <= 1'b0;
                sf    <= sh_next[WIDTH-1];
            end
        end else if (accept) begin
            sel_q <= alu_sel;
            if (is_shift && (shift_amt != '0)) begin
                result <= op_a;
                cnt    <= shift_amt;
                state  <= ST_SHIFT;
            end else begin
                result <= alu_res;
                zf     <= (alu_res == '0);
                cf     <= alu_cf;
                vf     <= alu_vf;
                sf     <= alu_res[WIDTH-1];
                state  <= ST_DONE;
            end
        end else if (state != ST_IDLE && (state != ST_DONE || out_ready)) begin
            // Result taken with nothing new arriving; also recovers an illegal encoding.
            state <= ST_IDLE;
        end
    end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Multi-cycle execute unit for the RISC-V core. It consumes the 4-bit `ALUsel` operation code produced by the ALU control decode stage, plus two operands, through a valid/ready handshake, and returns a registered result and condition flags. ADD, SUB, logic, compare and PASS complete in one cycle. Shifts are performed iteratively, one bit position per cycle, so the unit needs no barrel shifter. It sits between the operand-select muxes and the writeback/branch logic.

## Interface
- `WIDTH`, 32, datapath width in bits. Must be a power of two, ≥ 8.
- `SHW`, `$clog2(WIDTH)`, width of the shift amount. Derived; not overridden.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept a request this cycle.
- `alu_sel`  in  4  operation code, using the `ALU_*` encodings from `defines.v`.
- `op_a`  in  WIDTH  first operand (rs1).
- `op_b`  in  WIDTH  second operand (rs2, immediate, or LUI value).
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  registered result.
- `zf`, `cf`, `vf`, `sf`  out  1 each  zero, carry, overflow and sign flags. All registered.

## Operation
- **States:** IDLE, SHIFT, DONE. Reset state is IDLE.
- **`in_ready`:** `in_ready = (state==IDLE) | (state==DONE & out_ready)`. It is forced to 0 while `rst` is low.
- **Acceptance:** a request is accepted on an edge where `in_valid & in_ready`. `alu_sel`, `op_a` and `op_b` are sampled only at acceptance; later changes are ignored.
- **Single-cycle ops** go to DONE with the result written at the acceptance edge:
  - ADD: a+b.
  - SUB: a−b.
  - AND, OR, XOR: bitwise.
  - SLT: signed a<b, zero-extended to 1.
  - SLTU: unsigned a<b.
  - PASS: `op_b`.
- **Unknown codes** behave as PASS.
- **Shifts (SLL, SRL, SRA):**
  - `n = op_b[SHW-1:0]`; upper bits of `op_b` are ignored.
  - `n==0`: go to DONE with result = `op_a`.
  - `n>0`: load the working register with `op_a` and the counter with n, then go to SHIFT.
  - In SHIFT, each edge shifts the working register by one bit and decrements the counter. SRA replicates the MSB; SRL and SLL shift in 0.
  - The edge that shifts with counter==1 moves to DONE.
- **DONE:**
  - `out_valid=1`; `result` and the flags hold stable until `out_valid & out_ready`.
  - On that edge, go to IDLE, or, if a new request is accepted on the same edge, start it directly (back-to-back).
- **Flags** are written with `result` when entering DONE:
  - `zf = (result==0)`.
  - `sf = result[WIDTH-1]`.
  - ADD: `cf` = carry-out of a+b; `vf` = signed overflow.
  - SUB: computed as a+~b+1. `cf` = carry-out, so 1 means no borrow; `vf` = signed overflow.
  - All other ops: `cf=vf=0`.
- **Arithmetic** wraps modulo 2^WIDTH; carry is taken from a WIDTH+1-bit sum.

## Timing
- **Reset values:** `out_valid=0`, `result=0`, all flags 0, counter 0, state IDLE. `in_ready=0` during reset and 1 on the first cycle after release.
- **Reset mid-operation:** asserting `rst` in any state immediately (asynchronously) clears the state and outputs. The in-flight op is discarded, with no partial result.
- **Latency:** `out_valid` rises 1+n cycles after the acceptance edge, where n is the shift amount for shifts and 0 for all other ops.
- **`in_ready` in flight:** low for the whole of SHIFT, and low in DONE unless `out_ready` is high.
- **Throughput:** with `out_ready` tied high, one single-cycle op completes per cycle after the first.
- **Ordering:** exactly one result per accepted request, in acceptance order.
- **Combinational paths:** no combinational path from `in_valid` to `out_valid`. `in_ready` depends combinationally on `out_ready` only.

## Test plan
- ADD, a=0x7FFFFFFF, b=1 → `result`=0x80000000, vf=1, cf=0, sf=1, zf=0; `out_valid` exactly 1 cycle after accept.
- SUB 5−5 → 0, zf=1, cf=1. SLT a=0xFFFFFFFF, b=1 → 1. SLTU with the same operands → 0. PASS b=0x12345000 → 0x12345000. `alu_sel`=4'hF → `op_b`.
- SRA a=0x80000000, b=4 → 0xF8000000, `out_valid` 5 cycles after accept, `in_ready` low for the 4 SHIFT cycles. SLL b=0x20 (n=0) → `op_a`, latency 1. SRL a=0xF0, b=31 → 0, latency 32.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE → `result` and flags stable, `in_ready`=0. Then raise `out_ready` with `in_valid`=1 (XOR 0xFF,0x0F) → accepted on the same edge, next cycle `result`=0xF0.
- Reset mid-SHIFT (SLL by 10, `rst` low at cycle 3) → `out_valid`=0 and `result`=0 immediately; after release `in_ready`=1 and a fresh ADD 2+3 returns 5.
- Random stream of 1000 ops with random `out_ready`, checked against a reference model for result, flags, latency and ordering.
